// File: rtl/skew_mem_ctrl.sv
// Address/enable sequencer for the systolic input buffer: parallel fill on write, skewed drain on read.
// Define SKEW_MEM_DBUF_EN for ping-pong banking (address MSB = bank, read/write run concurrently).
module skew_mem_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 128,
`ifdef SKEW_MEM_DBUF_EN
  localparam int AW = ADDR_WIDTH + 1
`else
  localparam int AW = ADDR_WIDTH
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH:0]     num_row,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic                    wr_start,
  input  logic                    rd_start,
  output logic                    wr_busy,
  output logic                    rd_busy,
  output logic                    wr_done,
  output logic                    rd_done,
  output logic [SYS_ROW-1:0]      wr_en,
  output logic [SYS_ROW*AW-1:0]   wr_addr,
  output logic [SYS_ROW-1:0]      rd_en,
  output logic [SYS_ROW*AW-1:0]   rd_addr
);

  localparam int CNT_WIDTH = $clog2(DEPTH + SYS_ROW) + 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_N = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RD_TAIL = CNT_WIDTH'(SYS_ROW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef struct packed {
    state_e wr;
    state_e rd;
  } fsm_t;

  // Handshake: a start is a one-cycle request honoured only while its FSM is IDLE and the
  // interlock allows it; a refused start is dropped. busy is high for every RUN cycle and
  // done pulses for exactly one cycle afterwards, with busy already low.
  fsm_t                  fsm_q, fsm_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic [CNT_WIDTH-1:0]  n_clamp;
  logic                  wr_accept, rd_accept;

  logic                  wr_busy_d, rd_busy_d, wr_done_d, rd_done_d;
  logic [SYS_ROW-1:0]    wr_en_d, rd_en_d;
  logic [SYS_ROW*AW-1:0] wr_addr_d, rd_addr_d;
  logic [CNT_WIDTH-1:0]  lane_row;
  logic [ADDR_WIDTH-1:0] row_addr;

  assign n_clamp = CNT_WIDTH'((num_row > DEPTH_N) ? DEPTH_N : num_row);

`ifdef SKEW_MEM_DBUF_EN
  logic wr_bank_q, rd_bank_q, rd_bank_d;

  assign wr_accept = wr_start && (fsm_q.wr == IDLE);
  assign rd_accept = rd_start && (fsm_q.rd == IDLE);
  assign rd_bank_d = rd_accept ? ~wr_bank_q : rd_bank_q;

  // The write bank flips as the write leaves DONE; a read keeps the bank it latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      rd_bank_q <= rd_bank_d;
      if (fsm_q.wr == DONE) wr_bank_q <= ~wr_bank_q;
    end
  end
`else
  // Either FSM outside IDLE blocks the other; on a tie the write wins.
  assign wr_accept = wr_start && (fsm_q.wr == IDLE) && (fsm_q.rd == IDLE);
  assign rd_accept = rd_start && !wr_start && (fsm_q.rd == IDLE) && (fsm_q.wr == IDLE);
`endif

  always_comb begin
    fsm_d     = fsm_q;
    wr_cnt_d  = wr_cnt_q;
    wr_n_d    = wr_n_q;
    wr_base_d = wr_base_q;
    rd_cnt_d  = rd_cnt_q;
    rd_n_d    = rd_n_q;
    rd_base_d = rd_base_q;

    case (fsm_q.wr)
      IDLE: if (wr_accept) begin
        wr_n_d    = n_clamp;
        wr_base_d = base_addr;
        wr_cnt_d  = '0;
        fsm_d.wr  = (n_clamp == '0) ? DONE : RUN;
      end
      RUN: if (wr_cnt_q == wr_n_q - ONE) fsm_d.wr = DONE;
           else wr_cnt_d = wr_cnt_q + ONE;
      DONE:    fsm_d.wr = IDLE;
      default: fsm_d.wr = IDLE;
    endcase

    case (fsm_q.rd)
      IDLE: if (rd_accept) begin
        rd_n_d    = n_clamp;
        rd_base_d = base_addr;
        rd_cnt_d  = '0;
        fsm_d.rd  = (n_clamp == '0) ? DONE : RUN;
      end
      // The drain runs SYS_ROW-1 extra cycles so the last lane can finish its rows.
      RUN: if (rd_cnt_q == rd_n_q + RD_TAIL - ONE) fsm_d.rd = DONE;
           else rd_cnt_d = rd_cnt_q + ONE;
      DONE:    fsm_d.rd = IDLE;
      default: fsm_d.rd = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without a cycle of lag.
  always_comb begin
    wr_busy_d = (fsm_d.wr == RUN);
    rd_busy_d = (fsm_d.rd == RUN);
    wr_done_d = (fsm_d.wr == DONE);
    rd_done_d = (fsm_d.rd == DONE);
    wr_en_d   = '0;
    wr_addr_d = '0;
    rd_en_d   = '0;
    rd_addr_d = '0;
    lane_row  = '0;
    row_addr  = wr_base_d + ADDR_WIDTH'(wr_cnt_d);

    if (fsm_d.wr == RUN) begin
      wr_en_d = '1;
      for (int i = 0; i < SYS_ROW; i++) begin
`ifdef SKEW_MEM_DBUF_EN
        wr_addr_d[i*AW +: AW] = {wr_bank_q, row_addr};
`else
        wr_addr_d[i*AW +: AW] = row_addr;
`endif
      end
    end

    for (int i = 0; i < SYS_ROW; i++) begin
      lane_row = rd_cnt_d - CNT_WIDTH'(i);
      if ((fsm_d.rd == RUN) && (rd_cnt_d >= CNT_WIDTH'(i)) && (lane_row < rd_n_d)) begin
        rd_en_d[i] = 1'b1;
`ifdef SKEW_MEM_DBUF_EN
        rd_addr_d[i*AW +: AW] = {rd_bank_d, rd_base_d + ADDR_WIDTH'(lane_row)};
`else
        rd_addr_d[i*AW +: AW] = rd_base_d + ADDR_WIDTH'(lane_row);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q.wr  <= IDLE;
      fsm_q.rd  <= IDLE;
      wr_cnt_q  <= '0;
      wr_n_q    <= '0;
      wr_base_q <= '0;
      rd_cnt_q  <= '0;
      rd_n_q    <= '0;
      rd_base_q <= '0;
      wr_busy   <= 1'b0;
      rd_busy   <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      wr_en     <= '0;
      wr_addr   <= '0;
      rd_en     <= '0;
      rd_addr   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_n_q    <= wr_n_d;
      wr_base_q <= wr_base_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_n_q    <= rd_n_d;
      rd_base_q <= rd_base_d;
      wr_busy   <= wr_busy_d;
      rd_busy   <= rd_busy_d;
      wr_done   <= wr_done_d;
      rd_done   <= rd_done_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      rd_en     <= rd_en_d;
      rd_addr   <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_skew_mem_ctrl.sv
// Bench for skew_mem_ctrl: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (outputs derived from accept time, length and base).
module tb_skew_mem_ctrl;

  localparam int S     = 16;
  localparam int AWB   = 8;
  localparam int DEPTH = 128;
`ifdef SKEW_MEM_DBUF_EN
  localparam int AW    = AWB + 1;
  localparam bit DBUF  = 1'b1;
`else
  localparam int AW    = AWB;
  localparam bit DBUF  = 1'b0;
`endif

  typedef struct packed {
    logic          wr_busy;
    logic          rd_busy;
    logic          wr_done;
    logic          rd_done;
    logic [S-1:0]  wr_en;
    logic [S-1:0]  rd_en;
    logic [S*AW-1:0] wr_addr;
    logic [S*AW-1:0] rd_addr;
  } out_t;
  localparam int OUT_W = $bits(out_t);

  logic            clk;
  logic            rst;
  logic [AWB:0]    num_row;
  logic [AWB-1:0]  base_addr;
  logic            wr_start;
  logic            rd_start;
  logic            wr_busy, rd_busy, wr_done, rd_done;
  logic [S-1:0]    wr_en, rd_en;
  logic [S*AW-1:0] wr_addr, rd_addr;

  skew_mem_ctrl #(.SYS_ROW(S), .ADDR_WIDTH(AWB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .num_row(num_row), .base_addr(base_addr),
    .wr_start(wr_start), .rd_start(rd_start),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_done(wr_done), .rd_done(rd_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one record per direction (accept cycle, clamped length, base, bank)
  int t = 0;
  int wr_t0 = -1, wr_n = 0, wr_base = 0, wr_bnk = 0;
  int rd_t0 = -1, rd_n = 0, rd_base = 0, rd_bnk = 0;
  int bank = 0;
  int tests = 0, fails = 0;
  logic [OUT_W-1:0] exp_q[$];

  function automatic int wr_done_cyc();
    return wr_t0 + 1 + wr_n;
  endfunction

  function automatic int rd_len();
    return (rd_n == 0) ? 0 : rd_n + S - 1;
  endfunction

  function automatic int rd_done_cyc();
    return rd_t0 + 1 + rd_len();
  endfunction

  function automatic bit wr_idle(int u);
    return (wr_t0 < 0) || (u > wr_done_cyc());
  endfunction

  function automatic bit rd_idle(int u);
    return (rd_t0 < 0) || (u > rd_done_cyc());
  endfunction

  function automatic out_t predict(int u);
    out_t o;
    int k, j;
    o = '0;
    if (wr_t0 >= 0) begin
      k = u - wr_t0 - 1;
      if (k >= 0 && k < wr_n) begin
        o.wr_busy = 1'b1;
        o.wr_en   = '1;
        for (int i = 0; i < S; i++)
          o.wr_addr[i*AW +: AW] = AW'(((wr_base + k) % (1 << AWB)) + wr_bnk * (1 << AWB));
      end else if (k == wr_n) begin
        o.wr_done = 1'b1;
      end
    end
    if (rd_t0 >= 0) begin
      k = u - rd_t0 - 1;
      if (k >= 0 && k < rd_len()) begin
        o.rd_busy = 1'b1;
        for (int i = 0; i < S; i++) begin
          j = k - i;
          if (j >= 0 && j < rd_n) begin
            o.rd_en[i] = 1'b1;
            o.rd_addr[i*AW +: AW] = AW'(((rd_base + j) % (1 << AWB)) + rd_bnk * (1 << AWB));
          end
        end
      end else if (k == rd_len()) begin
        o.rd_done = 1'b1;
      end
    end
    return o;
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // driver: check this cycle's outputs, drive this cycle's inputs, predict the next cycle
  task automatic step(input bit r, input bit ws, input bit rs, input int nr, input int ba);
    out_t e;
    int n;
    bit wacc, racc;
    @(posedge clk);
    #1;
    t++;
    e = exp_q.pop_front();
    check("wr_busy", 256'(wr_busy), 256'(e.wr_busy));
    check("rd_busy", 256'(rd_busy), 256'(e.rd_busy));
    check("wr_done", 256'(wr_done), 256'(e.wr_done));
    check("rd_done", 256'(rd_done), 256'(e.rd_done));
    check("wr_en",   256'(wr_en),   256'(e.wr_en));
    check("rd_en",   256'(rd_en),   256'(e.rd_en));
    check("wr_addr", 256'(wr_addr), 256'(e.wr_addr));
    check("rd_addr", 256'(rd_addr), 256'(e.rd_addr));

    rst       = r;
    wr_start  = ws;
    rd_start  = rs;
    num_row   = (AWB + 1)'(nr);
    base_addr = AWB'(ba);

    if (r) begin
      wr_t0 = -1;
      rd_t0 = -1;
      bank  = 0;
    end else begin
      n = (nr > DEPTH) ? DEPTH : nr;
`ifdef SKEW_MEM_DBUF_EN
      wacc = ws && wr_idle(t);
      racc = rs && rd_idle(t);
`else
      wacc = ws && wr_idle(t) && rd_idle(t);
      racc = rs && !ws && wr_idle(t) && rd_idle(t);
`endif
      if (racc) begin
        rd_t0 = t; rd_n = n; rd_base = ba;
        rd_bnk = DBUF ? int'(bank == 0) : 0;
      end
      if (wr_t0 >= 0 && t == wr_done_cyc()) bank ^= 1;
      if (wacc) begin
        wr_t0 = t; wr_n = n; wr_base = ba; wr_bnk = DBUF ? bank : 0;
      end
    end
    exp_q.push_back(predict(t + 1));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; wr_start = 1'b0; rd_start = 1'b0; num_row = '0; base_addr = '0;
    repeat (2) @(posedge clk);
    exp_q.push_back('0);

    // reset state and idle outputs
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(2);
    // plain fill, base 0, four rows
    step(1'b0, 1'b1, 1'b0, 4, 0);   idle(8);
    // skewed drain of four rows
    step(1'b0, 1'b0, 1'b1, 4, 0);   idle(22);
    // clamp to DEPTH with address wrap
    step(1'b0, 1'b1, 1'b0, 200, 250); idle(132);
    // simultaneous starts, then a read during the write
    step(1'b0, 1'b1, 1'b1, 4, 0);   idle(2);
    step(1'b0, 1'b0, 1'b1, 4, 0);   idle(25);
    // reset during read cycle 7, then a fresh read
    step(1'b0, 1'b0, 1'b1, 4, 0);   idle(7);
    step(1'b1, 1'b0, 1'b0, 0, 0);   idle(2);
    step(1'b0, 1'b0, 1'b1, 4, 0);   idle(22);
    // zero-length transfers and bank alternation
    step(1'b0, 1'b1, 1'b0, 0, 0);   idle(3);
    step(1'b0, 1'b1, 1'b0, 0, 0);   idle(3);
    step(1'b0, 1'b0, 1'b1, 0, 0);   idle(3);
    step(1'b0, 1'b1, 1'b0, 3, 10);  idle(6);
    step(1'b0, 1'b0, 1'b1, 2, 255); idle(20);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 20)),
           int'($urandom_range(0, 255)));
    end
    idle(4);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
